// File: rtl/ide_xfer_engine.sv
// IDE device-side data-port transfer engine: sequences PIO and multiword-DMA
// transfers between the host data register and a 1-cycle-latency sector buffer.
module ide_xfer_engine #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 16,
   parameter int DMA_BURST = 16
) (
   input  logic              clk,
   input  logic              rst_,
   input  logic              start,
   input  logic              abort,
   input  logic              dir,
   input  logic              dma_mode,
   input  logic [ADDR_W:0]   count,
   input  logic              dior_in,
   input  logic              diow_in,
   input  logic              dmack_in,
   input  logic              data_sel,
   input  logic [DATA_W-1:0] bus_wdata,
   output logic [DATA_W-1:0] bus_rdata,
   output logic              drq,
   output logic              dmarq,
   output logic              iowait,
   output logic [ADDR_W-1:0] buf_addr,
   output logic [DATA_W-1:0] buf_wdata,
   output logic              buf_we,
   input  logic [DATA_W-1:0] buf_rdata,
   output logic [ADDR_W:0]   pos,
   output logic              busy,
   output logic              done,
   output logic              overrun
);

   localparam int BW = (DMA_BURST < 2) ? 1 : $clog2(DMA_BURST + 1);

   typedef enum logic [2:0] {S_IDLE, S_PIO, S_DMA_REQ, S_DMA_PAUSE, S_DONE} state_t;

   state_t          state, state_n;
   logic            dir_q;
   logic [ADDR_W:0] count_q;
   logic [ADDR_W:0] pos_n, pos_inc;
   logic [BW-1:0]   burst, burst_n;
   logic            dior_q, diow_q;
   logic [1:0]      wait_cnt;
   logic            rd_rise, wr_rise, strobe, word_evt, stray, accept, last;
   logic            busy_n, rd_dir_n, wr_evt;

   // Strobe edge detection and next-state / datapath decisions
   always_comb begin
      rd_rise  = dior_in & ~dior_q;
      wr_rise  = diow_in & ~diow_q;
      strobe   = dir_q ? wr_rise : rd_rise;
      pos_inc  = pos + 1'b1;
      last     = (pos_inc == count_q);
      word_evt = 1'b0;
      stray    = 1'b0;
      accept   = 1'b0;
      state_n  = state;
      pos_n    = pos;
      burst_n  = burst;
      case (state)
         S_IDLE: begin
            stray = (rd_rise | wr_rise) & (data_sel | ~dmack_in);
            if (start) begin
               accept  = 1'b1;
               pos_n   = '0;
               burst_n = '0;
               if (count == '0)   state_n = S_DONE;
               else if (dma_mode) state_n = S_DMA_REQ;
               else               state_n = S_PIO;
            end
         end
         S_PIO: begin
            word_evt = strobe & data_sel;
            if (word_evt) begin
               pos_n = pos_inc;
               if (last) state_n = S_DONE;
            end
         end
         S_DMA_REQ: begin
            word_evt = strobe & ~dmack_in;
            if (word_evt) begin
               pos_n   = pos_inc;
               burst_n = burst + 1'b1;
               if (last)                            state_n = S_DONE;
               else if (burst_n == BW'(DMA_BURST)) state_n = S_DMA_PAUSE;
            end
         end
         S_DMA_PAUSE: begin
            stray = (rd_rise | wr_rise) & ~dmack_in;
            if (dmack_in) begin
               state_n = S_DMA_REQ;
               burst_n = '0;
            end
         end
         S_DONE: state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
      // Abort overrides everything, including a start or a word in the same cycle
      if (abort) begin
         state_n  = S_IDLE;
         pos_n    = pos;
         burst_n  = burst;
         accept   = 1'b0;
         word_evt = 1'b0;
      end
      wr_evt   = word_evt & dir_q;
      busy_n   = (state_n == S_PIO) || (state_n == S_DMA_REQ) || (state_n == S_DMA_PAUSE);
      rd_dir_n = accept ? ~dir : ~dir_q;
      drq      = (state == S_PIO);
      dmarq    = (state == S_DMA_REQ);
      busy     = (state == S_PIO) || (state == S_DMA_REQ) || (state == S_DMA_PAUSE);
      iowait   = (wait_cnt != 2'd0);
   end

   // State, position and registered bus/buffer outputs
   always_ff @(posedge clk) begin
      if (!rst_) begin
         state     <= S_IDLE;
         dir_q     <= 1'b0;
         count_q   <= '0;
         pos       <= '0;
         burst     <= '0;
         dior_q    <= 1'b1;
         diow_q    <= 1'b1;
         wait_cnt  <= 2'd0;
         bus_rdata <= '0;
         buf_addr  <= '0;
         buf_wdata <= '0;
         buf_we    <= 1'b0;
         done      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state     <= state_n;
         pos       <= pos_n;
         burst     <= burst_n;
         dior_q    <= dior_in;
         diow_q    <= diow_in;
         bus_rdata <= buf_rdata;
         buf_we    <= wr_evt;
         done      <= (state == S_DONE) & ~abort;
         if (accept) begin
            dir_q   <= dir;
            count_q <= count;
            overrun <= 1'b0;
         end else if (stray) begin
            overrun <= 1'b1;
         end
         if (wr_evt) buf_wdata <= bus_wdata;
         // Writes present the pre-increment address; otherwise prefetch the next word
         buf_addr <= wr_evt ? pos[ADDR_W-1:0] : pos_n[ADDR_W-1:0];
         // Hold IORDY low for the two cycles the read prefetch takes
         if (busy_n && rd_dir_n && (accept || (pos_n != pos))) wait_cnt <= 2'd2;
         else if (!busy_n)                                     wait_cnt <= 2'd0;
         else if (wait_cnt != 2'd0)                            wait_cnt <= wait_cnt - 2'd1;
      end
   end

endmodule

// File: tb/tb_ide_xfer_engine.sv
// Self-checking bench for ide_xfer_engine: randomized PIO/DMA transfers checked
// against expectations derived from the transfer rules.
module tb_ide_xfer_engine;

   logic        clk = 1'b0;
   logic        rst_, start, abort, dir, dma_mode;
   logic        dior_in, diow_in, dmack_in, data_sel;
   logic [8:0]  count;
   logic [15:0] bus_wdata, bus_rdata, buf_wdata, buf_rdata;
   logic [7:0]  buf_addr;
   logic [8:0]  pos;
   logic        drq, dmarq, iowait, buf_we, busy, done, overrun;

   logic        start4;
   logic [4:0]  count4;
   logic [15:0] bus_rdata4, buf_wdata4, buf_rdata4;
   logic [3:0]  buf_addr4;
   logic [4:0]  pos4;
   logic        drq4, dmarq4, iowait4, buf_we4, busy4, done4, overrun4;

   logic [15:0] rmem [256];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   ide_xfer_engine #(.ADDR_W(8), .DATA_W(16), .DMA_BURST(16)) dut (
      .clk(clk), .rst_(rst_), .start(start), .abort(abort), .dir(dir), .dma_mode(dma_mode),
      .count(count), .dior_in(dior_in), .diow_in(diow_in), .dmack_in(dmack_in),
      .data_sel(data_sel), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .drq(drq),
      .dmarq(dmarq), .iowait(iowait), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
      .buf_we(buf_we), .buf_rdata(buf_rdata), .pos(pos), .busy(busy), .done(done),
      .overrun(overrun));

   ide_xfer_engine #(.ADDR_W(4), .DATA_W(16), .DMA_BURST(4)) dut4 (
      .clk(clk), .rst_(rst_), .start(start4), .abort(abort), .dir(dir), .dma_mode(dma_mode),
      .count(count4), .dior_in(dior_in), .diow_in(diow_in), .dmack_in(dmack_in),
      .data_sel(data_sel), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata4), .drq(drq4),
      .dmarq(dmarq4), .iowait(iowait4), .buf_addr(buf_addr4), .buf_wdata(buf_wdata4),
      .buf_we(buf_we4), .buf_rdata(buf_rdata4), .pos(pos4), .busy(busy4), .done(done4),
      .overrun(overrun4));

   // Read-only sector buffer with 1-cycle latency
   always @(posedge clk) buf_rdata <= rmem[buf_addr];
   assign buf_rdata4 = 16'h0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input bit rd);
      if (rd) dior_in = 1'b0; else diow_in = 1'b0;
      tick();
      dior_in = 1'b1;
      diow_in = 1'b1;
      tick();
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (iowait && n < 8) begin
         tick();
         n++;
      end
   endtask

   task automatic watch(input int cycles, output int dones, output int reqs);
      dones = 0;
      reqs  = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         dones += done;
         reqs  += (drq | dmarq);
      end
   endtask

   task automatic test_reset();
      rst_ = 1'b0;
      tick();
      checks++;
      if ({bus_rdata, drq, dmarq, iowait, buf_addr, buf_wdata, buf_we, pos, busy, done, overrun} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: drq=%b dmarq=%b iowait=%b busy=%b done=%b ovr=%b pos=%0d addr=%0d rdata=%h, required all 0",
                  drq, dmarq, iowait, busy, done, overrun, pos, buf_addr, bus_rdata);
      end
      rst_ = 1'b1;
      tick();
   endtask

   task automatic test_pio_read();
      int cnt, n, dones, reqs;
      cnt = $urandom_range(2, 6);
      dir = 1'b0; dma_mode = 1'b0; data_sel = 1'b1; count = 9'(cnt);
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < cnt; k++) begin
         wait_ready(n);
         checks++;
         if (n != 2) begin errors++; $display("[TB] FAIL pio_rd_iowait[%0d]: %0d cycles, required 2", k, n); end
         checks++;
         if (bus_rdata !== rmem[k]) begin errors++; $display("[TB] FAIL pio_rd_data[%0d]: got %h, required %h", k, bus_rdata, rmem[k]); end
         checks++;
         if (drq !== 1'b1) begin errors++; $display("[TB] FAIL pio_rd_drq[%0d]: got %b, required 1", k, drq); end
         if (k == 0) begin
            pulse(1'b0);
            checks++;
            if (pos !== 9'd0 || overrun !== 1'b0) begin
               errors++; $display("[TB] FAIL pio_rd_wrongdir: pos=%0d ovr=%b, required pos=0 ovr=0", pos, overrun);
            end
         end
         pulse(1'b1);
      end
      checks++;
      if (pos !== 9'(cnt) || drq !== 1'b0) begin
         errors++; $display("[TB] FAIL pio_rd_end: pos=%0d drq=%b, required pos=%0d drq=0", pos, drq, cnt);
      end
      watch(4, dones, reqs);
      checks++;
      if (dones != 1) begin errors++; $display("[TB] FAIL pio_rd_done: %0d pulses, required 1", dones); end
   endtask

   task automatic test_pio_write();
      int cnt, dones, reqs;
      logic [15:0] d;
      cnt = $urandom_range(3, 6);
      dir = 1'b1; dma_mode = 1'b0; data_sel = 1'b1; count = 9'(cnt);
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < cnt; k++) begin
         d = 16'($urandom);
         bus_wdata = d;
         pulse(1'b0);
         checks++;
         if (buf_we !== 1'b1 || buf_addr !== 8'(k) || buf_wdata !== d) begin
            errors++;
            $display("[TB] FAIL pio_wr_word[%0d]: we=%b addr=%0d data=%h, required we=1 addr=%0d data=%h",
                     k, buf_we, buf_addr, buf_wdata, k, d);
         end
         checks++;
         if (drq !== (k < cnt - 1) || iowait !== 1'b0) begin
            errors++; $display("[TB] FAIL pio_wr_drq[%0d]: drq=%b iowait=%b, required drq=%b iowait=0", k, drq, iowait, k < cnt - 1);
         end
         if (k == 0) begin
            count = 9'd0;
            start = 1'b1; tick(); start = 1'b0;
            checks++;
            if (busy !== 1'b1 || pos !== 9'd1) begin
               errors++; $display("[TB] FAIL start_while_busy: busy=%b pos=%0d, required busy=1 pos=1", busy, pos);
            end
         end
      end
      watch(4, dones, reqs);
      checks++;
      if (dones != 1 || pos !== 9'(cnt)) begin
         errors++; $display("[TB] FAIL pio_wr_done: %0d pulses pos=%0d, required 1 pulse pos=%0d", dones, pos, cnt);
      end
   endtask

   task automatic test_dma_read();
      int n, w, pauses, dones, reqs;
      bit exp;
      dir = 1'b0; dma_mode = 1'b1; data_sel = 1'b0; dmack_in = 1'b1; count = 9'd40;
      pauses = 0;
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < 40; k++) begin
         wait_ready(n);
         checks++;
         if (bus_rdata !== rmem[k] || n == 8) begin
            errors++; $display("[TB] FAIL dma_rd_data[%0d]: got %h, required %h", k, bus_rdata, rmem[k]);
         end
         dmack_in = 1'b0;
         pulse(1'b1);
         w = k + 1;
         exp = (w < 40) && (w % 16 != 0);
         checks++;
         if (dmarq !== exp) begin errors++; $display("[TB] FAIL dma_rd_dmarq[%0d]: got %b, required %b", w, dmarq, exp); end
         if (!dmarq && w < 40) begin
            dmack_in = 1'b1;
            tick();
            pauses++;
            checks++;
            if (dmarq !== 1'b1) begin errors++; $display("[TB] FAIL dma_rd_resume[%0d]: dmarq=%b, required 1", w, dmarq); end
         end
      end
      dmack_in = 1'b1;
      watch(4, dones, reqs);
      checks++;
      if (pauses != 2 || dones != 1 || pos !== 9'd40) begin
         errors++; $display("[TB] FAIL dma_rd_end: pauses=%0d dones=%0d pos=%0d, required 2/1/40", pauses, dones, pos);
      end
   endtask

   task automatic test_abort();
      int dones, reqs;
      dir = 1'b1; dma_mode = 1'b0; data_sel = 1'b1; count = 9'd8;
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         bus_wdata = 16'($urandom);
         pulse(1'b0);
      end
      abort = 1'b1; tick(); abort = 1'b0;
      checks++;
      if (drq !== 1'b0 || busy !== 1'b0 || pos !== 9'd2) begin
         errors++; $display("[TB] FAIL abort_state: drq=%b busy=%b pos=%0d, required 0/0/2", drq, busy, pos);
      end
      watch(3, dones, reqs);
      checks++;
      if (dones != 0) begin errors++; $display("[TB] FAIL abort_nodone: %0d pulses, required 0", dones); end
      pulse(1'b0);
      checks++;
      if (overrun !== 1'b1 || buf_we !== 1'b0) begin
         errors++; $display("[TB] FAIL abort_overrun: ovr=%b we=%b, required ovr=1 we=0", overrun, buf_we);
      end
   endtask

   task automatic test_zero_count();
      int dones, reqs;
      dir = 1'b0; dma_mode = 1'b1; count = 9'd0;
      start = 1'b1; tick(); start = 1'b0;
      checks++;
      if (done !== 1'b0 || overrun !== 1'b0 || (drq | dmarq) !== 1'b0) begin
         errors++; $display("[TB] FAIL zero_first: done=%b ovr=%b req=%b, required 0/0/0", done, overrun, drq | dmarq);
      end
      tick();
      checks++;
      if (done !== 1'b1 || (drq | dmarq) !== 1'b0) begin
         errors++; $display("[TB] FAIL zero_done: done=%b req=%b, required done=1 req=0", done, drq | dmarq);
      end
      start = 1'b1; abort = 1'b1; count = 9'd5; tick(); start = 1'b0; abort = 1'b0;
      watch(3, dones, reqs);
      checks++;
      if (dones != 0 || reqs != 0 || busy !== 1'b0) begin
         errors++; $display("[TB] FAIL start_abort: dones=%0d reqs=%0d busy=%b, required 0/0/0", dones, reqs, busy);
      end
   endtask

   task automatic test_wrap();
      logic [15:0] d;
      dir = 1'b1; dma_mode = 1'b0; data_sel = 1'b1; count4 = 5'd16;
      start4 = 1'b1; tick(); start4 = 1'b0;
      for (int k = 0; k < 16; k++) begin
         d = 16'($urandom);
         bus_wdata = d;
         pulse(1'b0);
         checks++;
         if (buf_we4 !== 1'b1 || buf_addr4 !== 4'(k) || buf_wdata4 !== d) begin
            errors++;
            $display("[TB] FAIL wrap_word[%0d]: we=%b addr=%0d data=%h, required we=1 addr=%0d data=%h",
                     k, buf_we4, buf_addr4, buf_wdata4, k, d);
         end
      end
      checks++;
      if (pos4 !== 5'd16 || drq4 !== 1'b0) begin errors++; $display("[TB] FAIL wrap_pos: pos=%0d drq=%b, required 16/0", pos4, drq4); end
      tick();
      checks++;
      if (buf_addr4 !== 4'd0 || done4 !== 1'b1) begin
         errors++; $display("[TB] FAIL wrap_addr: addr=%0d done=%b, required 0/1", buf_addr4, done4);
      end
   endtask

   task automatic test_reset_mid_dma();
      int n;
      dir = 1'b0; dma_mode = 1'b1; data_sel = 1'b0; dmack_in = 1'b1; count = 9'd20;
      start = 1'b1; tick(); start = 1'b0;
      dmack_in = 1'b0;
      for (int k = 0; k < 3; k++) begin
         wait_ready(n);
         pulse(1'b1);
      end
      rst_ = 1'b0;
      tick();
      checks++;
      if ({bus_rdata, drq, dmarq, iowait, buf_addr, buf_wdata, buf_we, pos, busy, done, overrun} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_mid_dma: dmarq=%b iowait=%b busy=%b pos=%0d addr=%0d rdata=%h, required all 0",
                  dmarq, iowait, busy, pos, buf_addr, bus_rdata);
      end
      rst_ = 1'b1;
      dmack_in = 1'b1;
      tick();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rmem[i] = 16'($urandom);
      rst_ = 1'b0; start = 1'b0; abort = 1'b0; dir = 1'b0; dma_mode = 1'b0;
      dior_in = 1'b1; diow_in = 1'b1; dmack_in = 1'b1; data_sel = 1'b0;
      count = 9'd0; bus_wdata = 16'h0; start4 = 1'b0; count4 = 5'd0;
      tick();
      test_reset();
      test_pio_read();
      test_pio_write();
      test_dma_read();
      test_abort();
      test_zero_count();
      test_wrap();
      test_reset_mid_dma();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
